conv1d_stream_engine: RTL and testbench

Parametrised 1-D convolution engine, successor to the fixed 32-pixel, 3-tap, fixed-kernel row convolver. It captures one packed pixel row and a runtime-loaded signed kernel on `start`, then computes every valid output position through a 2-stage multiply/add pipeline. Results leave on a valid/ready stream with index and last markers, replacing the wide result array. Optional stride-2 and ReLU modes feed the downstream pooling/activation stages.

---
 rtl/conv1d_stream_engine_if.sv | 17 +
 rtl/conv1d_stream_engine.sv | 177 +++++++++++++++++
 tb/tb_conv1d_stream_engine.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv1d_stream_engine_if.sv
// Result stream carrying one signed convolution output plus its position index
// and end-of-row marker from the engine to a downstream consumer.
interface conv1d_stream_engine_if #(
    parameter int ACC_W = 18,
    parameter int IDX_W = 5
) ();
    // A beat transfers on a rising edge where valid && ready; once valid is high,
    // data/idx/last stay stable and valid stays high until that transfer happens.
    logic                    valid;
    logic                    ready;
    logic signed [ACC_W-1:0] data;
    logic [IDX_W-1:0]        idx;
    logic                    last;

    modport master (output valid, output data, output idx, output last, input ready);
    modport slave  (input valid, input data, input idx, input last, output ready);
endinterface

// File: rtl/conv1d_stream_engine.sv
// 1-D signed convolution over one captured pixel row with a runtime kernel,
// optional stride-2 and ReLU, streamed out through a 2-stage multiply/add pipeline.
module conv1d_stream_engine #(
    parameter int DATA_W  = 8,
    parameter int ROW_LEN = 32,
    parameter int K       = 3,
    parameter int ACC_W   = 2*DATA_W + $clog2(K),
    parameter int IDX_W   = $clog2(ROW_LEN)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [ROW_LEN*DATA_W-1:0] i_pixel_row_data,
    input  logic [K*DATA_W-1:0]       i_kernel_in,
    input  logic                      i_stride2,
    input  logic                      i_relu_en,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [1:0]                o_dbg_state,
    conv1d_stream_engine_if.master    o_out
);

    localparam int PROD_W  = 2*DATA_W;
    localparam int NOUT_S1 = ROW_LEN - K + 1;
    localparam int NOUT_S2 = (ROW_LEN - K)/2 + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_pix  [ROW_LEN];
    logic signed [DATA_W-1:0]  r_kern [K];
    logic                      r_stride2;
    logic                      r_relu;
    logic [IDX_W-1:0]          r_p;
    logic                      r_issuing;

    logic                      r_s1_valid;
    logic signed [PROD_W-1:0]  r_prod [K];
    logic [IDX_W-1:0]          r_s1_idx;
    logic                      r_s1_last;

    logic                      r_out_valid;
    logic signed [ACC_W-1:0]   r_out_data;
    logic [IDX_W-1:0]          r_out_idx;
    logic                      r_out_last;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_adv;
    logic                      w_xfer;
    logic                      w_accept;
    logic [IDX_W-1:0]          w_last_p;
    logic [IDX_W:0]            w_base;
    logic signed [DATA_W-1:0]  w_tap  [K];
    logic signed [PROD_W-1:0]  w_prod [K];
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_res;

    // The whole pipeline, including the issue counter, moves only when the
    // output register is empty or being drained this cycle.
    assign w_adv    = !r_out_valid || o_out.ready;
    assign w_xfer   = r_out_valid && o_out.ready;
    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_last_p = r_stride2 ? IDX_W'(NOUT_S2 - 1) : IDX_W'(NOUT_S1 - 1);
    assign w_base   = r_stride2 ? {r_p, 1'b0} : {1'b0, r_p};

    always_comb begin
        for (int j = 0; j < K; j++) begin
            int pos;
            pos      = int'(w_base) + j;
            w_tap[j] = (pos < ROW_LEN) ? r_pix[pos] : '0;
            w_prod[j] = PROD_W'(r_kern[j]) * PROD_W'(w_tap[j]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < K; j++) begin
            w_sum = w_sum + ACC_W'(r_prod[j]);
        end
        w_res = (r_relu && w_sum[ACC_W-1]) ? '0 : w_sum;
    end

    // Operand and product payload registers carry no reset; their valids do.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int i = 0; i < ROW_LEN; i++) begin
                r_pix[i] <= i_pixel_row_data[i*DATA_W +: DATA_W];
            end
            for (int j = 0; j < K; j++) begin
                r_kern[j] <= i_kernel_in[j*DATA_W +: DATA_W];
            end
        end
        if ((r_state == ST_RUN) && w_adv && r_issuing) begin
            for (int j = 0; j < K; j++) begin
                r_prod[j] <= w_prod[j];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_stride2   <= 1'b0;
            r_relu      <= 1'b0;
            r_p         <= '0;
            r_issuing   <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            r_s1_last   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state   <= ST_RUN;
                        r_busy    <= 1'b1;
                        r_stride2 <= i_stride2;
                        r_relu    <= i_relu_en;
                        r_p       <= '0;
                        r_issuing <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_adv) begin
                        r_s1_valid <= r_issuing;
                        if (r_issuing) begin
                            r_s1_idx  <= r_p;
                            r_s1_last <= (r_p == w_last_p);
                            r_p       <= r_p + 1'b1;
                            if (r_p == w_last_p) begin
                                r_issuing <= 1'b0;
                            end
                        end
                        r_out_valid <= r_s1_valid;
                        if (r_s1_valid) begin
                            r_out_data <= w_res;
                            r_out_idx  <= r_s1_idx;
                            r_out_last <= r_s1_last;
                        end
                    end
                    if (w_xfer && r_out_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_dbg_state = r_state;
    assign o_out.valid = r_out_valid;
    assign o_out.data  = r_out_data;
    assign o_out.idx   = r_out_idx;
    assign o_out.last  = r_out_last;

endmodule

// File: tb/tb_conv1d_stream_engine.sv
// Bench for conv1d_stream_engine: default-size instance plus a 16-pixel, 5-tap
// instance, both checked against an integer reference model via expected queues.
module tb_conv1d_stream_engine;

  localparam int DW  = 8;
  localparam int RL  = 32;
  localparam int KK  = 3;
  localparam int AW  = 18;
  localparam int IW  = 5;
  localparam int EW  = 1 + IW + AW;
  localparam int RL2 = 16;
  localparam int K2  = 5;
  localparam int AW2 = 19;
  localparam int IW2 = 4;
  localparam int EW2 = 1 + IW2 + AW2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start, stride2, relu_en;
  logic [RL*DW-1:0] pix_bus;
  logic [KK*DW-1:0] kern_bus;
  logic             busy, done;
  logic [1:0]       dbg;

  logic              start2, stride2_b, relu_b;
  logic [RL2*DW-1:0] pix2_bus;
  logic [K2*DW-1:0]  kern2_bus;
  logic              busy2, done2;
  logic [1:0]        dbg2;

  conv1d_stream_engine_if #(.ACC_W(AW), .IDX_W(IW)) s_if ();
  conv1d_stream_engine_if #(.ACC_W(AW2), .IDX_W(IW2)) s2_if ();

  conv1d_stream_engine #(.DATA_W(DW), .ROW_LEN(RL), .K(KK)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_pixel_row_data(pix_bus), .i_kernel_in(kern_bus),
    .i_stride2(stride2), .i_relu_en(relu_en),
    .o_busy(busy), .o_done(done), .o_dbg_state(dbg), .o_out(s_if)
  );

  conv1d_stream_engine #(.DATA_W(DW), .ROW_LEN(RL2), .K(K2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2),
    .i_pixel_row_data(pix2_bus), .i_kernel_in(kern2_bus),
    .i_stride2(stride2_b), .i_relu_en(relu_b),
    .o_busy(busy2), .o_done(done2), .o_dbg_state(dbg2), .o_out(s2_if)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]  exp_q[$];
  logic [EW2-1:0] exp2_q[$];
  int checks = 0;
  int errors = 0;
  int n_xfer = 0;
  int n_done = 0;
  int n_xfer2 = 0;
  bit rdy_rand = 1'b0;
  int pix [RL];
  int kern [KK];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: direct evaluation of the dot product per output position.
  function automatic int model_row(input int s2, input int relu);
    int s, nout, acc;
    s = s2 ? 2 : 1;
    nout = (RL - KK) / s + 1;
    for (int n = 0; n < nout; n++) begin
      acc = 0;
      for (int j = 0; j < KK; j++) acc += kern[j] * pix[n*s + j];
      if (relu != 0 && acc < 0) acc = 0;
      exp_q.push_back({(n == nout-1) ? 1'b1 : 1'b0, IW'(n), AW'(acc)});
    end
    return nout;
  endfunction

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    s_if.ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    s2_if.ready = 1'b1;
  end

  task automatic pack_inputs();
    for (int i = 0; i < RL; i++) pix_bus[i*DW +: DW] = DW'(pix[i]);
    for (int j = 0; j < KK; j++) kern_bus[j*DW +: DW] = DW'(kern[j]);
  endtask

  task automatic rand_row();
    for (int i = 0; i < RL; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < KK; j++) kern[j] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Called #1 after a rising edge with the engine idle.
  task automatic run_row(input int s2, input int relu, input int inject);
    int nout, x0, d0;
    bit seen;
    pack_inputs();
    stride2 = s2[0];
    relu_en = relu[0];
    nout = model_row(s2, relu);
    x0 = n_xfer;
    d0 = n_done;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    @(posedge clk); #1;
    chk("valid_after_e1", s_if.valid, 0);
    @(posedge clk); #1;
    chk("valid_after_e2", s_if.valid, 1);
    chk("first_idx", s_if.idx, 0);
    seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(posedge clk); #1;
      start = (inject != 0 && (c == 4 || done)) ? 1'b1 : 1'b0;
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("idle_no_restart", busy, 0);
    chk("xfer_count", n_xfer - x0, nout);
    chk("done_count", n_done - d0, 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  // ---------------- monitors ----------------
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_word;
  logic [EW-1:0] m_word, m_exp;
  bit            done_pending = 1'b0;

  always @(negedge clk) begin
    m_word = {s_if.last, s_if.idx, s_if.data};
    if (!rst_n) begin
      prev_stall   = 1'b0;
      done_pending = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", s_if.valid, 1);
        chk("stall_payload_held", m_word, prev_word);
      end
      if (done_pending) begin
        chk("done_after_last", done, 1);
        chk("busy_with_done", busy, 1);
        done_pending = 1'b0;
      end else if (done) begin
        chk("done_unexpected", done, 0);
      end
      if (done) n_done++;
      if (s_if.valid && s_if.ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_result", 1, 0);
        end else begin
          m_exp = exp_q.pop_front();
          chk("result_data", $signed(s_if.data), $signed(m_exp[AW-1:0]));
          chk("result_last_idx", {s_if.last, s_if.idx}, m_exp[EW-1:AW]);
        end
        n_xfer++;
        if (s_if.last) done_pending = 1'b1;
      end
      prev_stall = s_if.valid && !s_if.ready;
      prev_word  = m_word;
    end
  end

  logic [EW2-1:0] m_exp2;
  always @(negedge clk) begin
    if (rst_n && s2_if.valid && s2_if.ready) begin
      if (exp2_q.size() == 0) begin
        chk("r2_extra_result", 1, 0);
      end else begin
        m_exp2 = exp2_q.pop_front();
        chk("r2_data", $signed(s2_if.data), $signed(m_exp2[AW2-1:0]));
        chk("r2_last_idx", {s2_if.last, s2_if.idx}, m_exp2[EW2-1:AW2]);
      end
      n_xfer2++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit hit;
    int acc2;
    start = 1'b0; stride2 = 1'b0; relu_en = 1'b0;
    pix_bus = '0; kern_bus = '0;
    start2 = 1'b0; stride2_b = 1'b0; relu_b = 1'b0;
    pix2_bus = '0; kern2_bus = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_valid", s_if.valid, 0);
    chk("reset_data", $signed(s_if.data), 0);
    chk("reset_idx", s_if.idx, 0);
    chk("reset_last", s_if.last, 0);
    chk("reset_done", done, 0);
    chk("reset_state", dbg, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse at pixel 5 through a Laplacian-style kernel.
    for (int i = 0; i < RL; i++) pix[i] = 0;
    pix[5] = 10;
    kern[0] = -1; kern[1] = 2; kern[2] = -1;
    run_row(0, 0, 0);

    // Most negative sums, then clamped by ReLU.
    for (int i = 0; i < RL; i++) pix[i] = -128;
    for (int j = 0; j < KK; j++) kern[j] = 127;
    run_row(0, 0, 0);
    run_row(0, 1, 0);

    // Stride 2 selecting even pixels.
    for (int i = 0; i < RL; i++) pix[i] = i;
    kern[0] = 1; kern[1] = 0; kern[2] = 0;
    run_row(1, 0, 0);

    // Random data under random backpressure.
    rdy_rand = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rand_row();
      run_row((r == 3) ? 1 : 0, r % 2, 0);
    end
    rdy_rand = 1'b0;
    @(posedge clk); #1;

    // Spurious start pulses during RUN and DONE.
    rand_row();
    run_row(0, 0, 1);

    // Reset in the middle of a row, then a clean row.
    rand_row();
    pack_inputs();
    stride2 = 1'b0;
    relu_en = 1'b0;
    void'(model_row(0, 0));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk); #1;
      if (s_if.valid && s_if.idx == IW'(10)) hit = 1'b1;
    end
    chk("reached_idx10", hit, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_valid", s_if.valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_idx", s_if.idx, 0);
    rst_n = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rand_row();
    run_row(0, 1, 0);

    // Smaller row with a wider kernel on the second instance.
    for (int i = 0; i < RL2; i++) pix2_bus[i*DW +: DW] = 8'sd127;
    for (int j = 0; j < K2; j++) kern2_bus[j*DW +: DW] = -8'sd128;
    for (int n = 0; n < RL2 - K2 + 1; n++) begin
      acc2 = 0;
      for (int j = 0; j < K2; j++) acc2 += 127 * (-128);
      exp2_q.push_back({(n == RL2 - K2) ? 1'b1 : 1'b0, IW2'(n), AW2'(acc2)});
    end
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clk); #1;
      if (done2) hit = 1'b1;
    end
    chk("r2_done_seen", hit, 1);
    @(posedge clk); #1;
    chk("r2_xfer_count", n_xfer2, RL2 - K2 + 1);
    chk("r2_queue_empty", exp2_q.size(), 0);
    chk("r2_busy_after", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
